// File: rtl/boot_sched_if.sv
//------------------------------------------------------------------------------
// Module      : boot_sched_if
// Description : Request/status bundle between warm-boot requesters and the
//               boot scheduler. The master side drives requests, the slave
//               side (boot_sched) returns acks and the SB_WARMBOOT controls.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface boot_sched_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]   req_valid;
  logic [2*N_REQ-1:0] req_sel;
  logic [N_REQ-1:0]   req_defer;
  logic               cancel;
  logic               wdt_kick;
  logic [N_REQ-1:0]   req_ack;
  logic               busy;
  logic               wdt_fired;
  logic [1:0]         wb_sel;
  logic               wb_boot;

  modport master (
    output req_valid, req_sel, req_defer, cancel, wdt_kick,
    input  req_ack, busy, wdt_fired, wb_sel, wb_boot
  );

  modport slave (
    input  req_valid, req_sel, req_defer, cancel, wdt_kick,
    output req_ack, busy, wdt_fired, wb_sel, wb_boot
  );
endinterface

`default_nettype wire

// File: rtl/boot_sched.sv
//------------------------------------------------------------------------------
// Module      : boot_sched
// Description : Arbitrates ice40 warm-boot requests, latches the granted image
//               select, optionally defers the boot, then holds S1/S0 stable
//               for one cycle before raising BOOT (terminal until reset).
//               Optional watchdog enabled by defining BOOT_SCHED_WDT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module boot_sched #(
  parameter int         N_REQ   = 3,
  parameter int         DELAY_W = 16,
  parameter int         DELAY   = 40000,
  parameter int         WDT_W   = 24,
  parameter logic [1:0] WDT_SEL = 2'b00
) (
  input  wire logic     clk,
  input  wire logic     rst,
  boot_sched_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_SETUP = 2'd2;
  localparam logic [1:0] ST_FIRE  = 2'd3;

  localparam logic [DELAY_W-1:0] C_DELAY = DELAY_W'(DELAY);

  logic [1:0]         state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [1:0]         sel_q, sel_d;
  logic               boot_q, boot_d;
  logic               fired_q, fired_d;

  logic [N_REQ-1:0]   gnt_oh;
  logic [1:0]         gnt_sel;
  logic               gnt_defer;
  logic               any_req;
  logic               wdt_req;

  // Fixed priority: lowest-index valid requester wins
  always_comb begin
    gnt_oh    = '0;
    gnt_sel   = 2'b00;
    gnt_defer = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        gnt_oh    = '0;
        gnt_oh[i] = 1'b1;
        gnt_sel   = bus.req_sel[2*i +: 2];
        gnt_defer = bus.req_defer[i];
      end
    end
  end

  assign any_req = |bus.req_valid;

`ifdef BOOT_SCHED_WDT_EN
  logic             armed_q;
  logic [WDT_W-1:0] wdt_q;

  // Watchdog arms on the first kick, counts only while idle, clears on kick
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q <= 1'b0;
      wdt_q   <= '0;
    end else if (bus.wdt_kick) begin
      armed_q <= 1'b1;
      wdt_q   <= '0;
    end else if (armed_q && (state_q == ST_IDLE)) begin
      wdt_q   <= wdt_q + WDT_W'(1);
    end
  end

  assign wdt_req = (state_q == ST_IDLE) && wdt_q[WDT_W-1];
`else
  logic [WDT_W-1:0] unused_wdt;

  assign unused_wdt = {WDT_W{bus.wdt_kick}};
  assign wdt_req    = 1'b0;
`endif

  // Next-state: grant, optional defer countdown, one SETUP cycle, then FIRE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = '0;
    sel_d   = sel_q;
    boot_d  = boot_q;
    fired_d = fired_q;
    case (state_q)
      ST_IDLE: begin
        if (wdt_req) begin
          // Watchdog outranks every requester and is never deferred
          sel_d   = WDT_SEL;
          fired_d = 1'b1;
          state_d = ST_SETUP;
        end else if (any_req) begin
          sel_d = gnt_sel;
          ack_d = gnt_oh;
          if (gnt_defer) begin
            cnt_d   = C_DELAY;
            state_d = ST_WAIT;
          end else begin
            state_d = ST_SETUP;
          end
        end
      end
      ST_WAIT: begin
        // Cancel wins over expiry; the counter saturates at zero
        if (bus.cancel) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_SETUP;
        end else begin
          cnt_d = cnt_q - DELAY_W'(1);
        end
      end
      ST_SETUP: begin
        state_d = ST_FIRE;
        boot_d  = 1'b1;
      end
      default: begin
        boot_d = 1'b1;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ack_q   <= '0;
      sel_q   <= 2'b00;
      boot_q  <= 1'b0;
      fired_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      sel_q   <= sel_d;
      boot_q  <= boot_d;
      fired_q <= fired_d;
    end
  end

  assign bus.req_ack   = ack_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.wdt_fired = fired_q;
  assign bus.wb_sel    = sel_q;
  assign bus.wb_boot   = boot_q;

endmodule

`default_nettype wire

// File: tb/tb_boot_sched.sv
//------------------------------------------------------------------------------
// Module      : tb_boot_sched
// Description : Self-checking bench for boot_sched (directed scenarios plus
//               randomized grants against a timing/priority reference model).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_boot_sched;

  localparam int         N_REQ   = 3;
  localparam int         DELAY_W = 16;
  localparam int         DELAY   = 5;
  localparam int         WDT_W   = 8;
  localparam logic [1:0] WDT_SEL = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  boot_sched_if #(.N_REQ(N_REQ)) bus ();

  boot_sched #(
    .N_REQ  (N_REQ),
    .DELAY_W(DELAY_W),
    .DELAY  (DELAY),
    .WDT_W  (WDT_W),
    .WDT_SEL(WDT_SEL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // One active edge, then settle on the falling edge for sampling/driving
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_sel   = '0;
    bus.req_defer = '0;
    bus.cancel    = 1'b0;
    bus.wdt_kick  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.req_ack !== 3'b000) begin n_bad++; $display("FAIL reset_ack: got %b expected 000", bus.req_ack); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.wdt_fired !== 1'b0) begin n_bad++; $display("FAIL reset_fired: got %b expected 0", bus.wdt_fired); end
    n_cmp++; if (bus.wb_sel !== 2'b00) begin n_bad++; $display("FAIL reset_sel: got %b expected 00", bus.wb_sel); end
    n_cmp++; if (bus.wb_boot !== 1'b0) begin n_bad++; $display("FAIL reset_boot: got %b expected 0", bus.wb_boot); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %b expected 0", bus.busy); end
  endtask

  // T1: immediate boot of requester 1
  task automatic test_immediate();
    do_reset();
    bus.req_valid = 3'b010;
    bus.req_sel   = 6'b00_01_00;
    tick();
    n_cmp++; if (bus.req_ack !== 3'b010) begin n_bad++; $display("FAIL t1_ack: got %b expected 010", bus.req_ack); end
    n_cmp++; if (bus.wb_sel !== 2'b01) begin n_bad++; $display("FAIL t1_sel: got %b expected 01", bus.wb_sel); end
    n_cmp++; if (bus.wb_boot !== 1'b0) begin n_bad++; $display("FAIL t1_boot_early: got %b expected 0", bus.wb_boot); end
    bus.req_valid = '0;
    tick();
    n_cmp++; if (bus.req_ack !== 3'b000) begin n_bad++; $display("FAIL t1_ack_pulse: got %b expected 000", bus.req_ack); end
    n_cmp++; if (bus.wb_boot !== 1'b1) begin n_bad++; $display("FAIL t1_boot: got %b expected 1", bus.wb_boot); end
    for (int k = 0; k < 4; k++) tick();
    n_cmp++; if (bus.wb_boot !== 1'b1) begin n_bad++; $display("FAIL t1_boot_hold: got %b expected 1", bus.wb_boot); end
  endtask

  // T2: simultaneous requests 1 and 2, requester 2 keeps asking
  task automatic test_priority();
    int acks2;
    do_reset();
    bus.req_valid = 3'b110;
    bus.req_sel   = 6'b01_10_00;
    tick();
    n_cmp++; if (bus.req_ack !== 3'b010) begin n_bad++; $display("FAIL t2_ack: got %b expected 010", bus.req_ack); end
    n_cmp++; if (bus.wb_sel !== 2'b10) begin n_bad++; $display("FAIL t2_sel: got %b expected 10", bus.wb_sel); end
    bus.req_valid = 3'b100;
    acks2 = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus.req_ack[2]) acks2++;
    end
    n_cmp++; if (acks2 !== 0) begin n_bad++; $display("FAIL t2_no_ack2: got %0d acks expected 0", acks2); end
    n_cmp++; if (bus.wb_sel !== 2'b10 || bus.wb_boot !== 1'b1) begin n_bad++; $display("FAIL t2_final: got sel=%b boot=%b expected sel=10 boot=1", bus.wb_sel, bus.wb_boot); end
  endtask

  // T3: deferred boot, rise at sample edge + DELAY + 2
  task automatic test_defer();
    int early;
    do_reset();
    bus.req_valid = 3'b001;
    bus.req_sel   = 6'b00_00_01;
    bus.req_defer = 3'b001;
    tick();
    n_cmp++; if (bus.req_ack !== 3'b001) begin n_bad++; $display("FAIL t3_ack: got %b expected 001", bus.req_ack); end
    bus.req_valid = '0;
    early = 0;
    for (int k = 1; k <= DELAY + 1; k++) begin
      tick();
      if (bus.wb_boot !== 1'b0 || bus.busy !== 1'b1) early++;
    end
    n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL t3_wait: got %0d bad wait cycles expected 0", early); end
    tick();
    n_cmp++; if (bus.wb_boot !== 1'b1) begin n_bad++; $display("FAIL t3_boot: got %b expected 1", bus.wb_boot); end
    n_cmp++; if (bus.wb_sel !== 2'b01) begin n_bad++; $display("FAIL t3_sel: got %b expected 01", bus.wb_sel); end
  endtask

  // T4: cancel during WAIT, then a fresh immediate request from requester 2
  task automatic test_cancel();
    do_reset();
    bus.req_valid = 3'b001;
    bus.req_sel   = 6'b10_00_01;
    bus.req_defer = 3'b001;
    tick();
    bus.req_valid = '0;
    tick();
    bus.cancel    = 1'b1;
    bus.req_valid = 3'b100;
    tick();
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL t4_idle: got busy=%b expected 0", bus.busy); end
    n_cmp++; if (bus.req_ack !== 3'b000) begin n_bad++; $display("FAIL t4_no_grant: got %b expected 000", bus.req_ack); end
    n_cmp++; if (bus.wb_sel !== 2'b01 || bus.wb_boot !== 1'b0) begin n_bad++; $display("FAIL t4_kept: got sel=%b boot=%b expected sel=01 boot=0", bus.wb_sel, bus.wb_boot); end
    bus.cancel = 1'b0;
    tick();
    n_cmp++; if (bus.req_ack !== 3'b100) begin n_bad++; $display("FAIL t4_regrant: got %b expected 100", bus.req_ack); end
    bus.req_valid = '0;
    tick();
    n_cmp++; if (bus.wb_boot !== 1'b1 || bus.wb_sel !== 2'b10) begin n_bad++; $display("FAIL t4_boot: got sel=%b boot=%b expected sel=10 boot=1", bus.wb_sel, bus.wb_boot); end
  endtask

  // Cancel outside WAIT must not stop an immediate boot
  task automatic test_cancel_ignored();
    do_reset();
    bus.cancel    = 1'b1;
    bus.req_valid = 3'b001;
    bus.req_sel   = 6'b00_00_10;
    tick();
    bus.req_valid = '0;
    tick();
    n_cmp++; if (bus.wb_boot !== 1'b1) begin n_bad++; $display("FAIL cancel_ignored: got boot=%b expected 1", bus.wb_boot); end
    bus.cancel = 1'b0;
  endtask

  // T5: asynchronous reset in the middle of WAIT with the request still held
  task automatic test_reset_mid_wait();
    do_reset();
    bus.req_valid = 3'b010;
    bus.req_sel   = 6'b00_11_00;
    bus.req_defer = 3'b010;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    n_cmp++; if (bus.busy !== 1'b0 || bus.req_ack !== 3'b000 || bus.wb_boot !== 1'b0) begin n_bad++; $display("FAIL t5_rst_ctl: got busy=%b ack=%b boot=%b expected 0 000 0", bus.busy, bus.req_ack, bus.wb_boot); end
    n_cmp++; if (bus.wb_sel !== 2'b00 || bus.wdt_fired !== 1'b0) begin n_bad++; $display("FAIL t5_rst_sel: got sel=%b fired=%b expected 00 0", bus.wb_sel, bus.wdt_fired); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_cmp++; if (bus.req_ack !== 3'b010 || bus.wb_sel !== 2'b11) begin n_bad++; $display("FAIL t5_regrant: got ack=%b sel=%b expected 010 11", bus.req_ack, bus.wb_sel); end
    bus.req_valid = '0;
  endtask

  // Randomized requests checked against priority/latency model
  task automatic test_random(input int iters);
    for (int it = 0; it < iters; it++) begin
      logic [N_REQ-1:0]   v;
      logic [N_REQ-1:0]   d;
      logic [2*N_REQ-1:0] s;
      logic [N_REQ-1:0]   exp_ack;
      logic [1:0]         exp_sel;
      int                 g;
      int                 t_boot;
      do_reset();
      v = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
      d = N_REQ'($urandom);
      s = (2*N_REQ)'($urandom);
      g = -1;
      for (int i = 0; i < N_REQ; i++) if (g < 0 && v[i]) g = i;
      exp_ack    = '0;
      exp_ack[g] = 1'b1;
      exp_sel    = s[2*g +: 2];
      t_boot     = d[g] ? DELAY + 2 : 1;
      bus.req_valid = v;
      bus.req_sel   = s;
      bus.req_defer = d;
      for (int k = 0; k <= t_boot + 2; k++) begin
        tick();
        if (k == 0) bus.req_valid = v & ~exp_ack;
        n_cmp++; if (bus.req_ack !== ((k == 0) ? exp_ack : 3'b000)) begin n_bad++; $display("FAIL rnd_ack it=%0d k=%0d: got %b expected %b", it, k, bus.req_ack, (k == 0) ? exp_ack : 3'b000); end
        n_cmp++; if (bus.wb_sel !== exp_sel || bus.busy !== 1'b1) begin n_bad++; $display("FAIL rnd_sel it=%0d k=%0d: got sel=%b busy=%b expected %b 1", it, k, bus.wb_sel, bus.busy, exp_sel); end
        n_cmp++; if (bus.wb_boot !== (k >= t_boot)) begin n_bad++; $display("FAIL rnd_boot it=%0d k=%0d: got %b expected %b", it, k, bus.wb_boot, (k >= t_boot)); end
      end
    end
  endtask

  // T6: watchdog behaviour (or its absence in the default build)
  task automatic test_wdt();
    do_reset();
`ifdef BOOT_SCHED_WDT_EN
    begin
      int first_busy;
      int acks;
      int bad_idle;
      bad_idle = 0;
      for (int k = 0; k < 300; k++) begin
        tick();
        if (bus.busy !== 1'b0) bad_idle++;
      end
      for (int r = 0; r < 3; r++) begin
        bus.wdt_kick = 1'b1;
        tick();
        bus.wdt_kick = 1'b0;
        for (int k = 0; k < 99; k++) begin
          tick();
          if (bus.busy !== 1'b0) bad_idle++;
        end
      end
      n_cmp++; if (bad_idle !== 0) begin n_bad++; $display("FAIL t6_no_boot: got %0d busy cycles expected 0", bad_idle); end
      bus.wdt_kick = 1'b1;
      tick();
      bus.wdt_kick = 1'b0;
      first_busy = -1;
      acks = 0;
      for (int k = 1; k <= 140; k++) begin
        tick();
        if (first_busy < 0 && bus.busy === 1'b1) first_busy = k;
        if (bus.req_ack !== 3'b000) acks++;
      end
      n_cmp++; if (first_busy !== (1 << (WDT_W - 1)) + 1) begin n_bad++; $display("FAIL t6_expiry: got first busy %0d expected %0d", first_busy, (1 << (WDT_W - 1)) + 1); end
      n_cmp++; if (bus.wb_sel !== WDT_SEL || bus.wdt_fired !== 1'b1 || bus.wb_boot !== 1'b1) begin n_bad++; $display("FAIL t6_boot: got sel=%b fired=%b boot=%b expected %b 1 1", bus.wb_sel, bus.wdt_fired, bus.wb_boot, WDT_SEL); end
      n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL t6_no_ack: got %0d acks expected 0", acks); end
    end
`else
    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 400; k++) begin
        bus.wdt_kick = (k % 50 == 0);
        tick();
        if (bus.busy !== 1'b0 || bus.wdt_fired !== 1'b0) bad++;
      end
      bus.wdt_kick = 1'b0;
      n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL t6_disabled: got %0d active cycles expected 0", bad); end
    end
`endif
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_immediate();
    test_priority();
    test_defer();
    test_cancel();
    test_cancel_ignored();
    test_reset_mid_wait();
    test_random(20);
    test_wdt();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
